// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 state, error-code and protocol definitions.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_XFER      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_NOACK   = 2'd2
    } ps2_err_e;

    // The stop bit is driven on the fall that follows data and parity.
    localparam int c_STOP_OFFSET = 2;
    localparam int c_BIT_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Brief    : Synchronises one PS/2 line, debounces it, flags falling edges.
// Revision : 1.0
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic line_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int c_CNT_W = $clog2(FILTER_LEN) + 1;

    logic [1:0]         r_sync;
    logic               r_filt;
    logic               r_fall;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differs;
    logic               w_commit;

    assign w_differs = (r_sync[1] != r_filt);
    assign w_commit  = w_differs && (r_cnt == c_CNT_W'(FILTER_LEN - 1));

    // Lines idle high, so the filter starts out believing the bus is released.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], line_i};
            r_fall <= w_commit && r_filt;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign filt_o = r_filt;
    assign fall_o = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter with ACK check/timeout.
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15_000,
    parameter int FILTER_LEN  = 4,
    parameter int DATA_BITS   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   tx_en_i,
    input  logic [DATA_BITS-1:0]   tx_data_i,
    input  logic                   ps2_clk_i,
    input  logic                   ps2_data_i,
    output logic                   ps2_clk_oe_o,
    output logic                   ps2_data_oe_o,
    output logic                   idle_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [1:0]             err_code_o,
    output logic [2:0]             state_o,
    output logic [c_BIT_CNT_W-1:0] bit_count_o
);

    localparam int c_INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int c_TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int c_INH_W       = $clog2(c_INHIBIT_CYC) + 1;
    localparam int c_TO_W        = $clog2(c_TIMEOUT_CYC) + 1;

    ps2_state_e             r_state, w_state_nxt;
    logic [DATA_BITS-1:0]   r_data, w_data_nxt;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [c_INH_W-1:0]     r_inh_cnt, w_inh_cnt_nxt;
    logic [c_TO_W-1:0]      r_to_cnt, w_to_cnt_nxt;
    logic                   r_data_oe, w_data_oe_nxt;
    ps2_err_e               r_err_code, w_err_code_nxt;

    logic                   w_clk_filt, w_clk_fall;
    logic                   w_data_filt, w_data_fall_unused;
    logic                   w_clk_oe, w_done, w_err, w_timeout;
    logic [c_BIT_CNT_W-1:0] w_bit_n;
    logic [DATA_BITS-1:0]   w_shift;
    logic                   w_parity;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .line_i   (ps2_clk_i),
        .filt_o   (w_clk_filt),
        .fall_o   (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .line_i   (ps2_data_i),
        .filt_o   (w_data_filt),
        .fall_o   (w_data_fall_unused)
    );

    // Fall n drives payload bit n-1, so the current count indexes the byte.
    assign w_bit_n  = r_bit_cnt + c_BIT_CNT_W'(1);
    assign w_shift  = r_data >> r_bit_cnt;
    assign w_parity = ~^r_data;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_data_oe  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_inh_cnt  <= w_inh_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_inh_cnt_nxt  = r_inh_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_data_oe_nxt  = r_data_oe;
        w_err_code_nxt = r_err_code;
        w_clk_oe       = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_timeout      = 1'b0;

        if (r_state == ST_XFER || r_state == ST_ACK || r_state == ST_WAIT_IDLE) begin
            w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
            w_timeout    = (r_to_cnt == c_TO_W'(c_TIMEOUT_CYC));
        end

        case (r_state)
            ST_IDLE: begin
                if (tx_en_i) begin
                    w_data_nxt     = tx_data_i;
                    w_err_code_nxt = ERR_NONE;
                    w_bit_cnt_nxt  = '0;
                    w_inh_cnt_nxt  = '0;
                    w_state_nxt    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                w_clk_oe      = 1'b1;
                w_inh_cnt_nxt = r_inh_cnt + c_INH_W'(1);
                if (r_inh_cnt == c_INH_W'(c_INHIBIT_CYC - 1)) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                w_clk_oe     = 1'b1;
                w_to_cnt_nxt = '0;
                w_state_nxt  = ST_XFER;
            end
            ST_XFER: begin
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = w_bit_n;
                    if (w_bit_n <= c_BIT_CNT_W'(DATA_BITS)) begin
                        w_data_oe_nxt = ~w_shift[0];
                    end else if (w_bit_n < c_BIT_CNT_W'(DATA_BITS + c_STOP_OFFSET)) begin
                        w_data_oe_nxt = ~w_parity;
                    end else begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = w_bit_n;
                    if (!w_data_filt) begin
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        w_err_code_nxt = ERR_NOACK;
                        w_err          = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_filt && w_data_filt) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase

        // A timeout overrides anything a coincident fall would have done.
        if (w_timeout) begin
            w_bit_cnt_nxt  = r_bit_cnt;
            w_data_oe_nxt  = 1'b0;
            w_err_code_nxt = ERR_TIMEOUT;
            w_done         = 1'b0;
            w_err          = 1'b1;
            w_state_nxt    = ST_IDLE;
        end
    end

    assign ps2_clk_oe_o  = w_clk_oe;
    assign ps2_data_oe_o = r_data_oe;
    assign idle_o        = (r_state == ST_IDLE);
    assign done_o        = w_done;
    assign err_o         = w_err;
    assign err_code_o    = r_err_code;
    assign state_o       = r_state;
    assign bit_count_o   = r_bit_cnt;

endmodule
`default_nettype wire
